// File: rtl/cache_axi_pkg.sv
// Shared types for the two-port cache-to-AXI arbiter: FSM encodings, AXI response codes, port indices.
// No logic, so no latency; flow control lives in the arbiter itself.
package cache_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic PORT_S0 = 1'b0;  // instruction-cache miss handler
  localparam logic PORT_S1 = 1'b1;  // data-cache miss handler

  // Master-side transaction id encodes the owning port.
  function automatic logic [3:0] owner_id(input logic owner);
    return {3'b000, owner};
  endfunction

endpackage

// File: rtl/axi_arb2.sv
// Two-requester grant logic with a registered owner; fixed priority (port 1) or round-robin with ARB_RR_EN.
// Owner updates one cycle after load; requests are only sampled, never held or acknowledged here.
module axi_arb2
  import cache_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       load,
  output logic       owner
);

  logic grant;

`ifdef ARB_RR_EN
  logic last;

  // Last-granted starts at 1 so the first contested grant goes to port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (load && (|req)) begin
      last <= grant;
    end
  end

  always_comb begin
    grant = req[1] ? PORT_S1 : PORT_S0;
    if (req == 2'b11) begin
      grant = ~last;
    end
  end
`else
  assign grant = req[1] ? PORT_S1 : PORT_S0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= PORT_S0;
    end else if (load && (|req)) begin
      owner <= grant;
    end
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Arbitrates I-cache (s0) and D-cache (s1) AXI3 masters onto one memory port; read and write channels independent. ARB_RR_EN selects round-robin.
// One cycle of arbitration latency per burst; beats are then passed through combinationally with no buffering.
// Backpressure passes straight through for the owner; the non-owner sees ready/valid held at 0 until the burst ends.
module cache_axi_arbiter
  import cache_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // slave port 0
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic [3:0]        s0_rid,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [7:0]        s0_awlen,
  input  logic [2:0]        s0_awsize,
  input  logic [1:0]        s0_awburst,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [3:0]        s0_wstrb,
  input  logic              s0_wlast,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  output logic [1:0]        s0_bresp,
  output logic [3:0]        s0_bid,
  // slave port 1
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic [3:0]        s1_rid,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [7:0]        s1_awlen,
  input  logic [2:0]        s1_awsize,
  input  logic [1:0]        s1_awburst,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [3:0]        s1_wstrb,
  input  logic              s1_wlast,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  output logic [1:0]        s1_bresp,
  output logic [3:0]        s1_bid,
  // master port
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [3:0]        m_arid,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [3:0]        m_rid,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic [3:0]        m_awid,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  input  logic [3:0]        m_bid,
  // debug
  output logic              rd_owner,
  output logic              wr_owner
);

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic      rd_load, wr_load;
  logic      rd_addr_ph, rd_data_ph, wr_addr_ph, wr_data_ph, wr_resp_ph;

  axi_arb2 u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({s1_arvalid, s0_arvalid}),
    .load  (rd_load),
    .owner (rd_owner)
  );

  axi_arb2 u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({s1_awvalid, s0_awvalid}),
    .load  (wr_load),
    .owner (wr_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    rd_load = 1'b0;
    case (rd_state)
      R_IDLE: if (s0_arvalid || s1_arvalid) begin
        rd_load = 1'b1;
        rd_next = R_ADDR;
      end
      R_ADDR: if (m_arvalid && m_arready) rd_next = R_DATA;
      R_DATA: if (m_rvalid && m_rready && m_rlast) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    wr_load = 1'b0;
    case (wr_state)
      W_IDLE: if (s0_awvalid || s1_awvalid) begin
        wr_load = 1'b1;
        wr_next = W_ADDR;
      end
      W_ADDR: if (m_awvalid && m_awready) wr_next = W_DATA;
      W_DATA: if (m_wvalid && m_wready && m_wlast) wr_next = W_RESP;
      W_RESP: if (m_bvalid && m_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Phase qualifiers are gated by rst so the bus goes quiet in the reset cycle itself.
  assign rd_addr_ph = !rst && (rd_state == R_ADDR);
  assign rd_data_ph = !rst && (rd_state == R_DATA);
  assign wr_addr_ph = !rst && (wr_state == W_ADDR);
  assign wr_data_ph = !rst && (wr_state == W_DATA);
  assign wr_resp_ph = !rst && (wr_state == W_RESP);

  // Read address
  assign m_arvalid  = rd_addr_ph && (rd_owner ? s1_arvalid : s0_arvalid);
  assign m_araddr   = rd_owner ? s1_araddr  : s0_araddr;
  assign m_arlen    = rd_owner ? s1_arlen   : s0_arlen;
  assign m_arsize   = rd_owner ? s1_arsize  : s0_arsize;
  assign m_arburst  = rd_owner ? s1_arburst : s0_arburst;
  assign m_arid     = owner_id(rd_owner);
  assign s0_arready = rd_addr_ph && (rd_owner == PORT_S0) && m_arready;
  assign s1_arready = rd_addr_ph && (rd_owner == PORT_S1) && m_arready;

  // Read data: routed by the registered owner, the returned rid is only passed along.
  assign m_rready  = rd_data_ph && (rd_owner ? s1_rready : s0_rready);
  assign s0_rvalid = rd_data_ph && (rd_owner == PORT_S0) && m_rvalid;
  assign s1_rvalid = rd_data_ph && (rd_owner == PORT_S1) && m_rvalid;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign s0_rid    = m_rid;
  assign s1_rid    = m_rid;

  // Write address
  assign m_awvalid  = wr_addr_ph && (wr_owner ? s1_awvalid : s0_awvalid);
  assign m_awaddr   = wr_owner ? s1_awaddr  : s0_awaddr;
  assign m_awlen    = wr_owner ? s1_awlen   : s0_awlen;
  assign m_awsize   = wr_owner ? s1_awsize  : s0_awsize;
  assign m_awburst  = wr_owner ? s1_awburst : s0_awburst;
  assign m_awid     = owner_id(wr_owner);
  assign s0_awready = wr_addr_ph && (wr_owner == PORT_S0) && m_awready;
  assign s1_awready = wr_addr_ph && (wr_owner == PORT_S1) && m_awready;

  // Write data
  assign m_wvalid  = wr_data_ph && (wr_owner ? s1_wvalid : s0_wvalid);
  assign m_wdata   = wr_owner ? s1_wdata : s0_wdata;
  assign m_wstrb   = wr_owner ? s1_wstrb : s0_wstrb;
  assign m_wlast   = wr_owner ? s1_wlast : s0_wlast;
  assign s0_wready = wr_data_ph && (wr_owner == PORT_S0) && m_wready;
  assign s1_wready = wr_data_ph && (wr_owner == PORT_S1) && m_wready;

  // Write response: any bresp value closes the burst.
  assign m_bready  = wr_resp_ph && (wr_owner ? s1_bready : s0_bready);
  assign s0_bvalid = wr_resp_ph && (wr_owner == PORT_S0) && m_bvalid;
  assign s1_bvalid = wr_resp_ph && (wr_owner == PORT_S1) && m_bvalid;
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;
  assign s0_bid    = m_bid;
  assign s1_bid    = m_bid;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: reset, single/contended reads, read-write overlap, error response, reset mid-burst, arbitration order.
module tb_cache_axi_arbiter;
  import cache_axi_pkg::*;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk, rst;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast, s0_awvalid, s0_awready;
  logic s0_wvalid, s0_wready, s0_wlast, s0_bvalid, s0_bready;
  logic [31:0] s0_araddr, s0_rdata, s0_awaddr, s0_wdata;
  logic [7:0] s0_arlen, s0_awlen;
  logic [2:0] s0_arsize, s0_awsize;
  logic [1:0] s0_arburst, s0_awburst, s0_rresp, s0_bresp;
  logic [3:0] s0_rid, s0_wstrb, s0_bid;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast, s1_awvalid, s1_awready;
  logic s1_wvalid, s1_wready, s1_wlast, s1_bvalid, s1_bready;
  logic [31:0] s1_araddr, s1_rdata, s1_awaddr, s1_wdata;
  logic [7:0] s1_arlen, s1_awlen;
  logic [2:0] s1_arsize, s1_awsize;
  logic [1:0] s1_arburst, s1_awburst, s1_rresp, s1_bresp;
  logic [3:0] s1_rid, s1_wstrb, s1_bid;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, m_awvalid, m_awready;
  logic m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize;
  logic [1:0] m_arburst, m_awburst, m_rresp, m_bresp;
  logic [3:0] m_arid, m_rid, m_awid, m_wstrb, m_bid;
  logic rd_owner, wr_owner;

  int n_chk = 0;
  int n_fail = 0;

  cache_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rid(s0_rid),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen),
    .s0_awsize(s0_awsize), .s0_awburst(s0_awburst), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_bvalid(s0_bvalid),
    .s0_bready(s0_bready), .s0_bresp(s0_bresp), .s0_bid(s0_bid),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rid(s1_rid),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen),
    .s1_awsize(s1_awsize), .s1_awburst(s1_awburst), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_bvalid(s1_bvalid),
    .s1_bready(s1_bready), .s1_bresp(s1_bresp), .s1_bid(s1_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .rd_owner(rd_owner), .wr_owner(wr_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every valid/ready the arbiter drives, packed for "bus quiet" checks.
  function automatic logic [14:0] busy();
    return {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s0_arready, s1_arready,
            s0_rvalid, s1_rvalid, s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid};
  endfunction

  task automatic set_ar(input bit own, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (own) begin s1_arvalid = v; s1_araddr = a; s1_arlen = l; end
    else     begin s0_arvalid = v; s0_araddr = a; s0_arlen = l; end
  endtask

  task automatic set_aw(input bit own, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (own) begin s1_awvalid = v; s1_awaddr = a; s1_awlen = l; end
    else     begin s0_awvalid = v; s0_awaddr = a; s0_awlen = l; end
  endtask

  task automatic set_w(input bit own, input logic v, input logic [31:0] d, input logic l);
    if (own) begin s1_wvalid = v; s1_wdata = d; s1_wlast = l; end
    else     begin s0_wvalid = v; s0_wdata = d; s0_wlast = l; end
  endtask

  // Called one cycle after the request: checks the forwarded AR then completes the handshake.
  task automatic ar_grant(input bit own, input logic [31:0] addr, input logic [7:0] len);
    chk("ar_fields", 128'({m_arvalid, m_araddr, m_arlen, m_arsize, m_arid, rd_owner}),
        128'({1'b1, addr, len, (own ? 3'd3 : 3'd2), {3'b000, own}, own}));
    m_arready = 1'b1;
    #1;
    chk("ar_ready_route", 128'({s1_arready, s0_arready}), 128'({own, !own}));
    tick();
    set_ar(own, 1'b0, 32'h0, 8'h0);
    m_arready = 1'b0;
  endtask

  task automatic r_beats(input bit own, input int n, input int total, input logic [1:0] resp);
    for (int i = 0; i < n; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hA000 + 32'(i);
      m_rresp  = resp;
      m_rlast  = (i == total - 1);
      #1;
      chk("r_route", 128'({s1_rvalid, s0_rvalid, m_rready}), 128'({own, !own, 1'b1}));
      chk("r_payload", 128'(own ? {s1_rdata, s1_rresp, s1_rlast} : {s0_rdata, s0_rresp, s0_rlast}),
          128'({32'hA000 + 32'(i), resp, (i == total - 1)}));
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic do_read(input bit own, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] resp);
    set_ar(own, 1'b1, addr, len);
    #1;
    chk("ar_latency", 128'(m_arvalid), 128'(0));
    tick();
    ar_grant(own, addr, len);
    r_beats(own, int'(len) + 1, int'(len) + 1, resp);
    chk("r_done_idle", 128'({m_arvalid, m_rready, s0_rvalid, s1_rvalid}), 128'(0));
  endtask

  task automatic do_write(input bit own, input logic [31:0] addr, input int beats, input logic [1:0] resp);
    set_aw(own, 1'b1, addr, 8'(beats - 1));
    #1;
    chk("aw_latency", 128'(m_awvalid), 128'(0));
    tick();
    chk("aw_fields", 128'({m_awvalid, m_awaddr, m_awlen, m_awid, wr_owner}),
        128'({1'b1, addr, 8'(beats - 1), {3'b000, own}, own}));
    m_awready = 1'b1;
    #1;
    chk("aw_ready_route", 128'({s1_awready, s0_awready}), 128'({own, !own}));
    tick();
    set_aw(own, 1'b0, 32'h0, 8'h0);
    m_awready = 1'b0;
    for (int i = 0; i < beats; i++) begin
      set_w(own, 1'b1, 32'hB000 + 32'(i), (i == beats - 1));
      m_wready = 1'b1;
      #1;
      chk("w_route", 128'({m_wvalid, m_wdata, m_wstrb, m_wlast, s1_wready, s0_wready}),
          128'({1'b1, 32'hB000 + 32'(i), (own ? 4'hC : 4'h3), (i == beats - 1), own, !own}));
      tick();
    end
    set_w(own, 1'b0, 32'h0, 1'b0);
    m_wready = 1'b0;
    m_bvalid = 1'b1;
    m_bresp  = resp;
    #1;
    chk("b_route", 128'({s1_bvalid, s0_bvalid, m_bready, (own ? s1_bresp : s0_bresp)}),
        128'({own, !own, 1'b1, resp}));
    tick();
    m_bvalid = 1'b0;
    m_bresp  = OKAY;
    #1;
    chk("b_done_idle", 128'({m_bready, m_awvalid, s0_bvalid, s1_bvalid}), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    s0_arvalid = 0; s0_araddr = 0; s0_arlen = 0; s0_arsize = 3'd2; s0_arburst = 2'd1; s0_rready = 1;
    s0_awvalid = 0; s0_awaddr = 0; s0_awlen = 0; s0_awsize = 3'd2; s0_awburst = 2'd1;
    s0_wvalid = 0; s0_wdata = 0; s0_wstrb = 4'h3; s0_wlast = 0; s0_bready = 1;
    s1_arvalid = 0; s1_araddr = 0; s1_arlen = 0; s1_arsize = 3'd3; s1_arburst = 2'd1; s1_rready = 1;
    s1_awvalid = 0; s1_awaddr = 0; s1_awlen = 0; s1_awsize = 3'd3; s1_awburst = 2'd1;
    s1_wvalid = 0; s1_wdata = 0; s1_wstrb = 4'hC; s1_wlast = 0; s1_bready = 1;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = OKAY; m_rlast = 0; m_rid = 4'h0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = OKAY; m_bid = 4'h0;

    // Reset with requests and returning beats present: everything must stay quiet.
    s0_arvalid = 1; s1_awvalid = 1; m_rvalid = 1; m_bvalid = 1; m_arready = 1;
    tick();
    tick();
    chk("reset_quiet", 128'(busy()), 128'(0));
    chk("reset_owners", 128'({rd_owner, wr_owner}), 128'(0));
    s0_arvalid = 0; s1_awvalid = 0; m_rvalid = 0; m_bvalid = 0; m_arready = 0;
    rst = 1'b0;
    tick();

    // Single 16-beat I-cache read.
    do_read(1'b0, 32'h1FC0_0000, 8'd15, OKAY);

    // Contended read: port 1 first, port 0 one idle cycle after rlast; SLVERR still ends the burst.
    set_ar(1'b0, 1'b1, 32'h0000_0100, 8'd3);
    set_ar(1'b1, 1'b1, 32'h0000_0200, 8'd3);
    #1;
    tick();
    ar_grant(1'b1, 32'h0000_0200, 8'd3);
    r_beats(1'b1, 4, 4, OKAY);
    chk("contend_gap", 128'({m_arvalid, m_rready, s0_arready}), 128'(0));
    tick();
    ar_grant(1'b0, 32'h0000_0100, 8'd3);
    r_beats(1'b0, 4, 4, SLVERR);
    chk("contend_done", 128'({m_arvalid, m_rready}), 128'(0));

    // D-cache write-back overlapping an I-cache read.
    set_ar(1'b0, 1'b1, 32'h0000_2000, 8'd15);
    set_aw(1'b1, 1'b1, 32'h0000_1000, 8'd15);
    #1;
    tick();
    chk("conc_addr", 128'({m_arvalid, m_awvalid, rd_owner, wr_owner, m_araddr, m_awaddr}),
        128'({4'b1101, 32'h0000_2000, 32'h0000_1000}));
    m_arready = 1; m_awready = 1;
    tick();
    set_ar(1'b0, 1'b0, 32'h0, 8'h0);
    set_aw(1'b1, 1'b0, 32'h0, 8'h0);
    m_arready = 0; m_awready = 0;
    for (int i = 0; i < 16; i++) begin
      m_rvalid = 1; m_rdata = 32'hC000 + 32'(i); m_rlast = (i == 15);
      set_w(1'b1, 1'b1, 32'hD000 + 32'(i), (i == 15));
      m_wready = 1;
      #1;
      chk("conc_overlap", 128'({m_rready, s0_rvalid, s1_rvalid, s0_rdata, m_wvalid, s1_wready, s0_wready, m_wdata}),
          128'({3'b110, 32'hC000 + 32'(i), 3'b110, 32'hD000 + 32'(i)}));
      tick();
    end
    m_rvalid = 0; m_rlast = 0; m_wready = 0;
    set_w(1'b1, 1'b0, 32'h0, 1'b0);
    m_bvalid = 1; m_bresp = OKAY;
    #1;
    chk("conc_b", 128'({s1_bvalid, s0_bvalid, m_bready}), 128'(3'b101));
    tick();
    m_bvalid = 0;
    #1;
    chk("conc_idle", 128'(busy()), 128'(0));

    // SLVERR write response, then a fresh AW must be accepted.
    do_write(1'b1, 32'h0000_3000, 1, SLVERR);
    do_write(1'b1, 32'h0000_4000, 2, OKAY);

    // Reset at beat 5 of a 16-beat read while a write waits in its address phase.
    set_aw(1'b1, 1'b1, 32'h0000_6000, 8'd15);
    set_ar(1'b1, 1'b1, 32'h0000_5000, 8'd15);
    #1;
    tick();
    ar_grant(1'b1, 32'h0000_5000, 8'd15);
    r_beats(1'b1, 4, 16, OKAY);
    chk("pre_reset_busy", 128'({m_awvalid, m_rready, wr_owner}), 128'(3'b111));
    m_rvalid = 1; m_rdata = 32'hEEEE_0005;
    set_aw(1'b1, 1'b0, 32'h0, 8'h0);
    rst = 1'b1;
    #1;
    chk("reset_same_cycle", 128'(busy()), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("reset_next_cycle", 128'({busy(), rd_owner, wr_owner}), 128'(0));
    m_rvalid = 0;
    do_read(1'b0, 32'h0000_7000, 8'd0, OKAY);
    do_write(1'b0, 32'h0000_8000, 1, OKAY);

    // Three back-to-back dual requests after reset: 0,1,0 round-robin, else always port 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bit w;
      w = RR ? bit'(k % 2) : 1'b1;
      set_ar(1'b0, 1'b1, 32'h0000_1000, 8'd0);
      set_ar(1'b1, 1'b1, 32'h0000_2000, 8'd0);
      tick();
      ar_grant(w, w ? 32'h0000_2000 : 32'h0000_1000, 8'd0);
      r_beats(w, 1, 1, OKAY);
    end
    set_ar(1'b0, 1'b0, 32'h0, 8'h0);
    set_ar(1'b1, 1'b0, 32'h0, 8'h0);
    tick();
    chk("final_idle", 128'(busy()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
CACHE_AXI_ARBITER -- requirements
Module: cache_axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all AR/AW buses.
REQ-002 SHALL have parameter DATA_W, default 32, data width of all R/W buses.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports: clk  input  1  sole clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports s0_ar*/s0_r*/s0_aw*/s0_w*/s0_b*  mixed  AXI3-style  slave port 0 (instruction-cache miss handler); valid/ready/last 1, addr ADDR_W, data DATA_W, len 8, size 3, burst 2, strb 4, resp 2, id 4.
REQ-006 SHALL have ports s1_ar*/s1_r*/s1_aw*/s1_w*/s1_b*  mixed  same widths  slave port 1 (data-cache miss handler).
REQ-007 SHALL have ports m_ar*/m_r*/m_aw*/m_w*/m_b*  mixed  same widths  single master port to the memory bus.
REQ-008 SHALL have port rd_owner  output  1  index of the port owning the read channel (debug).
REQ-009 SHALL have port wr_owner  output  1  index of the port owning the write channel (debug).

Function
REQ-010 SHALL arbitrate read and write channels independently; one read burst and one write burst may be in flight at the same time.
REQ-011 SHALL run the read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
- R_IDLE: any sN_arvalid latches the grant into rd_owner and moves to R_ADDR (one cycle of arbitration latency).
- R_ADDR: the m_ar* fields carry the owner's fields. m_arvalid equals the owner's arvalid. On m_arvalid&&m_arready, moves to R_DATA.
- R_DATA: m_r* is routed to the owner and m_rready equals the owner's rready. On m_rvalid&&m_rready&&m_rlast, moves to R_IDLE.
REQ-012 SHALL run the write FSM W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
- W_ADDR: ends on the AW handshake.
- W_DATA: forwards only the owner's W beats and ends on the W handshake with wlast.
- W_RESP: routes B to the owner and ends on m_bvalid&&m_bready, whatever the bresp value.
REQ-013 SHALL drive the non-owner's arready, rvalid, awready, wready and bvalid to 0 at all times.
REQ-014 SHALL forward bresp and rresp unmodified; a non-OKAY response still completes the burst.
REQ-015 SHALL drive m_arid and m_awid as {3'b000, owner}, and SHALL ignore the returned rid/bid for routing.
REQ-016 SHALL add no combinational path from any m_*ready to any m_*valid.
REQ-017 SHALL NOT hold an sN_*valid beat while not granted; arbitration only samples valid.
REQ-018 SHALL, with both ports requesting in the same idle cycle, grant port 1 under fixed priority.
REQ-019 SHALL keep a grant until its burst completes; a higher-priority request during a burst waits.
REQ-020 SHALL reach R_IDLE directly from R_DATA after rlast, so a new grant can issue in the next cycle.

Reset
REQ-021 SHALL, on rst, put both FSMs in IDLE and clear rd_owner and wr_owner to 0.
REQ-022 SHALL, on rst, drive every m_*valid, m_rready, m_bready and every sN_*ready/valid output to 0.
REQ-023 SHALL, on rst mid-burst, abandon the burst without draining it; the bus is reset in the same cycle.

Configuration
REQ-024 SHALL, with ARB_RR_EN defined, use round-robin arbitration.
- A per-channel last-granted bit is reset to 1.
- On a simultaneous request, the port not granted last wins.
REQ-025 SHALL, with ARB_RR_EN undefined, use fixed priority with port 1 winning (REQ-018).

Structure
REQ-026 SHALL place the read/write FSM state encodings, the AXI response codes (OKAY/EXOKAY/SLVERR/DECERR) and the port index constants in the shared package cache_axi_pkg.
REQ-027 SHALL implement the grant logic in sub-module axi_arb2 and instantiate it twice, once for the read channel and once for the write channel.

Verification
REQ-028 SHALL verify a single read: s0 AR addr 0x1FC00000, len 15 -> m_araddr 0x1FC00000, m_arid 0; 16 beats reach s0 only; s1_rvalid stays 0.
REQ-029 SHALL verify simultaneous reads: s0 and s1 arvalid in the same cycle, fixed mode -> s1 granted first, s0 granted on the cycle after s1's rlast.
REQ-030 SHALL verify concurrency: an s1 write-back (16 beats, addr 0x00001000) runs during an s0 read -> both complete and the read and write channels overlap in time.
REQ-031 SHALL verify an error response: m_bresp=SLVERR on s1's burst -> s1_bresp=SLVERR, the FSM returns to W_IDLE and the next AW is accepted.
REQ-032 SHALL verify round-robin with ARB_RR_EN: three back-to-back dual requests -> grants alternate 0,1,0 after reset.
REQ-033 SHALL verify reset mid-burst: rst at beat 5 of 16 -> all valids are 0 in the next cycle, both FSMs are IDLE, and a fresh request is granted.
